// File: rtl/step_motor_pkg.sv
// Shared types and constants for the stepper motor controller.
// Holds the FSM state encoding, the coil phase table and the BCD wrap value.
package step_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Entry i lives at bits [4*i +: 4]: 0 = 1100, 1 = 0110, 2 = 0011, 3 = 1001.
  localparam logic [15:0] PHASE_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] phase_drive(input logic [1:0] idx);
    return PHASE_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/step_motor_ctrl_sense_sync.sv
// Two-flop synchronizer plus rising-edge detector for the motor sense input.
// rise_pulse is high for one clk cycle per synchronized low-to-high transition.
module sense_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/step_motor_ctrl.sv
// Stepper motor move controller: accepts step/direction requests, drives the
// four coil phases at CLK_DIV cycles per step, holds, and flags stalls.
module step_motor_ctrl
  import step_motor_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 1000,
  parameter int unsigned HOLD_CYC    = 50,
  parameter int unsigned STALL_STEPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_steps,
  input  logic       abort,
  input  logic       motor_sense,
  output logic [3:0] step_motor,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] sense_bcd
);

  localparam int unsigned PRESC_W = $clog2(CLK_DIV);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 2);
  localparam int unsigned STALL_W = $clog2(STALL_STEPS + 2);

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE   = PRESC_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [HOLD_W-1:0]  HOLD_ONE    = HOLD_W'(1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_STEPS);
  localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         remain_q, remain_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [3:0]         bcd_q, bcd_d;

  logic sense_rise;
  logic accept;

  sense_sync u_sense_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (motor_sense),
    .rise_pulse (sense_rise)
  );

  assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_FAULT);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign accept     = cmd_valid && cmd_ready;
  assign step_motor = busy ? phase_drive(phase_q) : '0;
  assign done       = done_q;
  assign fault      = fault_q;
  assign sense_bcd  = bcd_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    stall_d  = stall_q;
    hold_d   = hold_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    fault_d  = fault_q;
    bcd_d    = bcd_q;

    unique case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (accept) begin
          dir_d    = cmd_dir;
          remain_d = cmd_steps;
          fault_d  = 1'b0;
          bcd_d    = '0;
          presc_d  = '0;
          stall_d  = '0;
          hold_d   = '0;
          if (cmd_steps == 8'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN, ST_HOLD: begin
        // Sense edges count whenever a move is active; a coincident step
        // below leaves the stall counter cleared instead of incrementing it.
        if (sense_rise) begin
          bcd_d   = (bcd_q == BCD_MAX) ? '0 : bcd_q + 4'd1;
          stall_d = '0;
        end

        if (abort) begin
          state_d  = ST_IDLE;
          remain_d = '0;
        end else if (stall_q >= STALL_LIMIT) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else if (state_q == ST_RUN) begin
          if (presc_q == PRESC_LAST) begin
            presc_d  = '0;
            phase_d  = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
            remain_d = remain_q - 8'd1;
            if (!sense_rise) begin
              stall_d = stall_q + STALL_ONE;
            end
            if (remain_q == 8'd1) begin
              if (HOLD_CYC == 0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_HOLD;
                hold_d  = '0;
              end
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end else begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      presc_q  <= '0;
      remain_q <= '0;
      stall_q  <= '0;
      hold_q   <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      stall_q  <= stall_d;
      hold_q   <= hold_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      bcd_q    <= bcd_d;
    end
  end

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Scoreboard bench for step_motor_ctrl with CLK_DIV=4, HOLD_CYC=3, STALL_STEPS=8.
// Expected coil patterns and done pulses are queued with their due cycle at request time.
module tb_step_motor_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic       abort;
  logic       motor_sense;
  logic [3:0] step_motor;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] sense_bcd;

  step_motor_ctrl #(
    .CLK_DIV     (4),
    .HOLD_CYC    (3),
    .STALL_STEPS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_steps   (cmd_steps),
    .abort       (abort),
    .motor_sense (motor_sense),
    .step_motor  (step_motor),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .sense_bcd   (sense_bcd)
  );

  typedef struct {
    logic [3:0] sm;
    int         t;
  } sm_exp_t;

  sm_exp_t    sm_q[$];
  int         done_q[$];
  int         cyc;
  int         n_checks;
  int         n_errors;
  logic [1:0] tb_phase;
  logic       prev_busy;
  logic [3:0] prev_sm;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] tbl(input logic [1:0] p);
    case (p)
      2'd0:    return 4'b1100;
      2'd1:    return 4'b0110;
      2'd2:    return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  // Coil pattern scoreboard: one entry per new pattern seen while busy.
  initial begin
    prev_busy = 1'b0;
    prev_sm   = 4'b0000;
  end
  always @(negedge clk) begin
    sm_exp_t e;
    if (!rst && busy && (!prev_busy || step_motor != prev_sm)) begin
      if (sm_q.size() == 0) begin
        check("sm_extra", step_motor, 4'b0000);
      end else begin
        e = sm_q.pop_front();
        check("sm_val", step_motor, e.sm);
        check("sm_cyc", cyc, e.t);
      end
    end
    prev_busy <= busy;
    prev_sm   <= step_motor;
  end

  always @(negedge clk) begin
    int t;
    if (!rst && done) begin
      if (done_q.size() == 0) begin
        check("done_extra", done, 1'b0);
      end else begin
        t = done_q.pop_front();
        check("done_cyc", cyc, t);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", busy, 1'b0);
  endtask

  // Called at a negedge with the DUT ready; returns one negedge later (cyc == acc).
  task automatic start_move(input int n, input logic dir, input int nseen,
                            input bit exp_done, output int acc);
    sm_exp_t e;
    check("ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = 8'(n);
    acc = cyc + 1;
    if (n > 0) begin
      e.sm = tbl(tb_phase);
      e.t  = acc;
      sm_q.push_back(e);
      for (int k = 1; k <= nseen; k++) begin
        tb_phase = dir ? tb_phase + 2'd1 : tb_phase - 2'd1;
        e.sm = tbl(tb_phase);
        e.t  = acc + 4 * k;
        sm_q.push_back(e);
      end
    end
    if (exp_done) done_q.push_back((n == 0) ? acc : acc + 4 * n + 3);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int a;
    n_checks    = 0;
    n_errors    = 0;
    tb_phase    = 2'd0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_dir     = 1'b0;
    cmd_steps   = 8'd0;
    abort       = 1'b0;
    motor_sense = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sm", step_motor, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_bcd", sense_bcd, 4'd0);
    check("rst_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Forward move of 3 with one sense edge per step.
    start_move(3, 1'b1, 3, 1'b1, a);
    for (int k = 1; k <= 3; k++) begin
      wait_until(a + 4 * k - 2);
      motor_sense = 1'b1;
      wait_until(a + 4 * k);
      motor_sense = 1'b0;
    end
    wait_idle(100);
    check("fwd_bcd", sense_bcd, 4'd3);
    check("fwd_fault", fault, 1'b0);
    check("fwd_sm_idle", step_motor, 4'b0000);
    @(negedge clk);

    // Bring phase back to 0, then reverse 2 wrapping through phase 3.
    start_move(1, 1'b1, 1, 1'b1, a);
    wait_idle(100);
    @(negedge clk);
    start_move(2, 1'b0, 2, 1'b1, a);
    wait_idle(100);
    @(negedge clk);

    // Stall: no sense edges, fault after the 8th step.
    start_move(20, 1'b1, 8, 1'b0, a);
    wait_until(a + 32);
    check("stall_pre_fault", fault, 1'b0);
    check("stall_pre_busy", busy, 1'b1);
    wait_until(a + 33);
    check("stall_fault", fault, 1'b1);
    check("stall_sm", step_motor, 4'b0000);
    check("stall_busy", busy, 1'b0);
    check("stall_ready", cmd_ready, 1'b1);
    @(negedge clk);
    start_move(1, 1'b1, 1, 1'b1, a);
    check("fault_cleared", fault, 1'b0);
    wait_idle(100);
    @(negedge clk);

    // Abort coincident with the 2nd step.
    start_move(5, 1'b1, 1, 1'b0, a);
    wait_until(a + 7);
    abort = 1'b1;
    wait_until(a + 8);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_sm", step_motor, 4'b0000);
    check("abort_ready", cmd_ready, 1'b1);
    repeat (6) @(negedge clk);
    check("abort_no_done", sm_q.size() + done_q.size(), 0);

    // 11 periodic sense edges, then one edge landing on the 8th unsensed step.
    start_move(20, 1'b1, 20, 1'b1, a);
    for (int j = 0; j < 11; j++) begin
      wait_until(a + 1 + 4 * j);
      motor_sense = 1'b1;
      wait_until(a + 3 + 4 * j);
      motor_sense = 1'b0;
    end
    wait_until(a + 73);
    motor_sense = 1'b1;
    wait_until(a + 75);
    motor_sense = 1'b0;
    wait_idle(200);
    check("wrap_bcd", sense_bcd, 4'd2);
    check("prio_fault", fault, 1'b0);
    @(negedge clk);

    // Zero-step request completes without leaving IDLE.
    start_move(0, 1'b1, 0, 1'b1, a);
    check("zero_busy0", busy, 1'b0);
    @(negedge clk);
    check("zero_busy1", busy, 1'b0);
    @(negedge clk);

    // Reset in the middle of a move.
    start_move(5, 1'b1, 1, 1'b0, a);
    wait_until(a + 1);
    motor_sense = 1'b1;
    wait_until(a + 3);
    motor_sense = 1'b0;
    wait_until(a + 5);
    check("mid_bcd", sense_bcd, 4'd1);
    rst = 1'b1;
    #1;
    check("mrst_sm", step_motor, 4'b0000);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_fault", fault, 1'b0);
    check("mrst_bcd", sense_bcd, 4'd0);
    check("mrst_ready", cmd_ready, 1'b1);
    tb_phase = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Phase index restarts from 0 after reset.
    start_move(1, 1'b1, 1, 1'b1, a);
    wait_idle(100);
    repeat (6) @(negedge clk);
    check("sm_queue_empty", sm_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
